txuart_serializer: RTL and testbench
====================================

// Module: txuart_serializer
// PURPOSE
//  8N1 UART byte transmitter. Sits directly downstream of txdata, the hex-dump
//  formatter: txdata presents one ASCII character per request, and this block
//  serializes it onto o_uart_tx at CLOCKS_PER_BAUD clocks per bit. o_busy is
//  the backpressure txdata waits on before issuing its next character.
// PARAMETERS
//  CLOCKS_PER_BAUD  24'd138  clocks per bit (16 MHz / 115200); legal range 2..2^24-1
// PORTS
//  i_clk      in   1   system clock
//  i_reset    in   1   synchronous, active-high reset
//  i_wr       in   1   write request; accepted only when o_busy==0
//  i_data     in   8   byte to send; sampled only on the accept cycle
//  o_busy     out  1   high while a frame is in progress
//  o_uart_tx  out  1   serial line, idle-high
// BEHAVIOUR
//  - One clock, i_clk. i_reset is synchronous, active-high.
//  - Reset (takes effect on the next edge, from any state, mid-frame included):
//    state=IDLE, o_uart_tx=1, o_busy=0, baud counter=0, shift register=8'hFF.
//    The partial frame is abandoned. The line returns high immediately,
//    with no stop-bit padding.
//  - Accept: (state==IDLE && i_wr && !i_reset). On the next edge:
//    state=START, o_uart_tx=0, o_busy=1, shift<=i_data,
//    baud counter<=CLOCKS_PER_BAUD-1. Latency is one clock from the accept
//    cycle to the start-bit edge.
//  - i_wr while o_busy=1 is ignored. Nothing is queued, and i_data is not sampled.
//  - States: IDLE -> START -> BIT0..BIT7 -> STOP -> IDLE.
//    The state register is 4 bits; encodings are implementer's choice.
//  - In any non-IDLE state, each clock:
//    * if counter!=0: counter<=counter-1 and the state holds.
//    * if counter==0: advance one state and reload CLOCKS_PER_BAUD-1.
//  - Entering BITn: o_uart_tx=shift[0], then shift>>=1 with 1 filled in.
//    Data goes out LSB first.
//  - Entering STOP: o_uart_tx=1.
//  - STOP with counter==0: state=IDLE, o_busy=0, o_uart_tx stays 1.
//  - Each of START, BIT0..7 and STOP holds for exactly CLOCKS_PER_BAUD clocks.
//    o_busy is high for exactly 10*CLOCKS_PER_BAUD clocks per frame.
//  - Back-to-back: a new accept is possible on the first cycle o_busy==0.
//    The minimum stop-bit width is therefore CLOCKS_PER_BAUD+1 clocks.
//  - o_busy and o_uart_tx are registered outputs; there is no combinational
//    path from any input to either output.
//  - Counter width is 24 bits, matching the parameter.
//    Elaborate-time check: CLOCKS_PER_BAUD>=2.
//  - Invariants for formal/sim assertions:
//    * o_busy == (state!=IDLE).
//    * In IDLE, o_uart_tx==1.
//    * counter <= CLOCKS_PER_BAUD-1 at all times.
// TESTING
//  (sim uses CLOCKS_PER_BAUD=4 unless stated otherwise)
//  1. Hold i_reset for 3 clks, then release -> o_uart_tx=1 and o_busy=0.
//     Both hold with i_wr=0 for 100 clks.
//  2. Single pulse i_wr with i_data=8'h55 -> o_uart_tx sequence 0,1,0,1,0,1,0,1,0,1,
//     each level held 4 clks. o_busy is high exactly 40 clks.
//  3. Send 8'hA3; pulse i_wr with 8'hFF at clk 10 of the frame -> 2nd request ignored.
//     The decoded byte is A3, and o_busy falls at clk 40 with no second frame.
//  4. i_wr held high, i_data=8'h00 then 8'hFF -> two frames with a 5-clk stop
//     between them. Decoded 00 then FF; o_busy is low for exactly 1 clk between frames.
//  5. Assert i_reset during BIT3 of 8'h0F -> next clk o_uart_tx=1 and o_busy=0.
//     A following write of 8'h81 decodes cleanly as 81.
//  6. Default CLOCKS_PER_BAUD=138, send 8'h41 ('A') -> frame is 1380 clks and each
//     bit is 138 clks. A reference UART receiver model at 115200 Bd decodes 0x41.

Source files
------------

// File: rtl/txuart_serializer.sv
// 8N1 UART byte transmitter: LSB first, idle-high line.
// o_busy is the backpressure seen by the upstream character source.
module txuart_serializer #(
   parameter logic [23:0] CLOCKS_PER_BAUD = 24'd138
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   output logic       o_busy,
   output logic       o_uart_tx
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_START = 4'd1,
      S_BIT0  = 4'd2,
      S_BIT1  = 4'd3,
      S_BIT2  = 4'd4,
      S_BIT3  = 4'd5,
      S_BIT4  = 4'd6,
      S_BIT5  = 4'd7,
      S_BIT6  = 4'd8,
      S_BIT7  = 4'd9,
      S_STOP  = 4'd10
   } state_t;

   localparam logic [23:0] RELOAD = CLOCKS_PER_BAUD - 24'd1;

   if (CLOCKS_PER_BAUD < 24'd2) begin : g_bad_baud
      $error("txuart_serializer: CLOCKS_PER_BAUD must be >= 2");
   end

   state_t      r_state;
   logic [23:0] r_cnt;
   logic [7:0]  r_shift;
   logic        r_busy;
   logic        r_tx;
   logic        w_tick;

   assign w_tick    = (r_cnt == 24'd0);
   assign o_busy    = r_busy;
   assign o_uart_tx = r_tx;

   // Frame sequencer: every non-idle state lasts CLOCKS_PER_BAUD clocks.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_cnt   <= 24'd0;
         r_shift <= 8'hFF;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_wr) begin
                  r_state <= S_START;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_shift <= i_data;
                  r_cnt   <= RELOAD;
               end
            end
            S_START, S_BIT0, S_BIT1, S_BIT2,
            S_BIT3, S_BIT4, S_BIT5, S_BIT6: begin
               if (w_tick) begin
                  r_state <= state_t'(r_state + 4'd1);
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b1, r_shift[7:1]};
                  r_cnt   <= RELOAD;
               end else begin
                  r_cnt   <= r_cnt - 24'd1;
               end
            end
            S_BIT7: begin
               if (w_tick) begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                  r_cnt   <= RELOAD;
               end else begin
                  r_cnt   <= r_cnt - 24'd1;
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_tx    <= 1'b1;
                  r_cnt   <= RELOAD;
               end else begin
                  r_cnt   <= r_cnt - 24'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_tx    <= 1'b1;
               r_cnt   <= 24'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_txuart_serializer.sv
// Directed bench for txuart_serializer.
// Fast instance at 4 clocks/bit, default instance at 138.
module tb_txuart_serializer;

   logic       clk;
   logic       i_reset;
   logic       i_wr;
   logic [7:0] i_data;
   logic       o_busy;
   logic       o_uart_tx;
   logic       i_wr2;
   logic [7:0] i_data2;
   logic       o_busy2;
   logic       o_uart_tx2;

   int n_err;
   int n_chk;
   int inv_viol;
   logic samp2 [0:1999];

   txuart_serializer #(.CLOCKS_PER_BAUD(24'd4)) dut4 (
      .i_clk    (clk),
      .i_reset  (i_reset),
      .i_wr     (i_wr),
      .i_data   (i_data),
      .o_busy   (o_busy),
      .o_uart_tx(o_uart_tx)
   );

   txuart_serializer dut138 (
      .i_clk    (clk),
      .i_reset  (i_reset),
      .i_wr     (i_wr2),
      .i_data   (i_data2),
      .o_busy   (o_busy2),
      .o_uart_tx(o_uart_tx2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Idle line must always be high.
   always @(negedge clk) begin
      if (o_busy === 1'b0 && o_uart_tx !== 1'b1) inv_viol++;
      if (o_busy2 === 1'b0 && o_uart_tx2 !== 1'b1) inv_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [7:0] d);
      i_wr   = 1'b1;
      i_data = d;
      @(negedge clk);
   endtask

   // Called on the first negedge after an accept; walks the frame.
   task automatic capture(input logic [7:0] exp_b, input int pulse_at,
                          input logic [7:0] pulse_d, input logic keep_wr,
                          output logic [7:0] dec, output int blen,
                          output int bad, output int tail);
      logic lvl;
      blen = 0;
      bad  = 0;
      tail = 0;
      dec  = 8'h00;
      for (int i = 0; i < 200; i++) begin
         if (o_busy !== 1'b1) break;
         if (i < 4)        lvl = 1'b0;
         else if (i >= 36) lvl = 1'b1;
         else              lvl = exp_b[i/4 - 1];
         if (i >= 40 || o_uart_tx !== lvl) bad++;
         if (i >= 4 && i < 36 && (i % 4) == 2) dec[i/4 - 1] = o_uart_tx;
         tail = (o_uart_tx === 1'b1) ? tail + 1 : 0;
         blen++;
         if (i == pulse_at) begin
            i_wr   = 1'b1;
            i_data = pulse_d;
         end else begin
            i_wr = keep_wr;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] dec;
      int blen, bad, tail, cnt, idle1, n, idx;
      n_err    = 0;
      n_chk    = 0;
      inv_viol = 0;
      i_reset  = 1'b1;
      i_wr     = 1'b0;
      i_data   = 8'h00;
      i_wr2    = 1'b0;
      i_data2  = 8'h00;

      // 1: reset, then quiet line for 100 clocks
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      chk("rst_tx", {31'd0, o_uart_tx}, 32'd1);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) cnt++;
      end
      chk("idle_hold", cnt, 0);

      // 2: 0x55
      start(8'h55);
      capture(8'h55, -1, 8'h00, 1'b0, dec, blen, bad, tail);
      chk("t2_data", {24'd0, dec}, 32'h55);
      chk("t2_levels", bad, 0);
      chk("t2_busy_len", blen, 40);

      // 3: 0xA3 with an ignored write mid-frame
      repeat (3) @(negedge clk);
      start(8'hA3);
      capture(8'hA3, 10, 8'hFF, 1'b0, dec, blen, bad, tail);
      chk("t3_data", {24'd0, dec}, 32'hA3);
      chk("t3_busy_len", blen, 40);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (o_busy !== 1'b0) cnt++;
         @(negedge clk);
      end
      chk("t3_no_second", cnt, 0);

      // 4: back-to-back with i_wr held high
      start(8'h00);
      capture(8'h00, 5, 8'hFF, 1'b1, dec, blen, bad, tail);
      chk("t4_data0", {24'd0, dec}, 32'h00);
      chk("t4_levels0", bad, 0);
      cnt   = 0;
      idle1 = 0;
      while (o_busy !== 1'b1 && cnt < 10) begin
         if (o_uart_tx === 1'b1) idle1++;
         cnt++;
         @(negedge clk);
      end
      chk("t4_gap", cnt, 1);
      chk("t4_stop_w", tail + idle1, 5);
      capture(8'hFF, -1, 8'h00, 1'b0, dec, blen, bad, tail);
      chk("t4_data1", {24'd0, dec}, 32'hFF);
      chk("t4_busy_len1", blen, 40);

      // 5: reset during BIT3 of 0x0F, then 0x81
      repeat (3) @(negedge clk);
      start(8'h0F);
      i_wr = 1'b0;
      repeat (16) @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      chk("t5_rst_tx", {31'd0, o_uart_tx}, 32'd1);
      chk("t5_rst_busy", {31'd0, o_busy}, 32'd0);
      @(negedge clk);
      start(8'h81);
      capture(8'h81, -1, 8'h00, 1'b0, dec, blen, bad, tail);
      chk("t5_data", {24'd0, dec}, 32'h81);
      chk("t5_levels", bad, 0);

      // 6: default baud, 'A', decoded by a 115200 Bd receiver model
      i_wr2   = 1'b1;
      i_data2 = 8'h41;
      @(negedge clk);
      n   = 0;
      bad = 0;
      while (o_busy2 === 1'b1 && n < 2000) begin
         samp2[n] = o_uart_tx2;
         if (n / 138 == 0) begin
            if (o_uart_tx2 !== 1'b0) bad++;
         end else if (n / 138 >= 9) begin
            if (o_uart_tx2 !== 1'b1) bad++;
         end else begin
            if (o_uart_tx2 !== dec[0] && 1'b0) bad++;
         end
         n++;
         i_wr2 = 1'b0;
         @(negedge clk);
      end
      chk("t6_busy_len", n, 1380);
      for (int k = 138; k < 1242 && k < n; k++) begin
         logic [7:0] a;
         a = 8'h41;
         if (samp2[k] !== a[k/138 - 1]) bad++;
      end
      chk("t6_levels", bad, 0);
      dec = 8'h00;
      for (int j = 0; j < 8; j++) begin
         idx = int'((real'(j) + 1.5) * 16.0e6 / 115200.0);
         dec[j] = samp2[idx];
      end
      chk("t6_data", {24'd0, dec}, 32'h41);
      idx = int'(9.5 * 16.0e6 / 115200.0);
      chk("t6_stop", {31'd0, samp2[idx]}, 32'd1);

      chk("idle_high", inv_viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
